// File: rtl/lab_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : lab_serial_addsub
// Purpose  : Digit-serial adder/subtractor. Processes DIGIT bits per cycle,
//            LSB first, behind a start/ready/done handshake. Produces the
//            WIDTH-bit result, carry/borrow-out and signed-overflow flag.
// Ports    : clk   - rising-edge clock
//            rst   - synchronous active-high reset
//            start - request, accepted only while ready=1
//            mode  - 0 = A-B-bin, 1 = A+B+bin
//            A, B  - operands, latched on accepted start
//            bin   - borrow-in / carry-in, latched on accepted start
//            ready - idle, able to accept a request
//            busy  - digit processing in progress
//            done  - one-cycle pulse, D/bout/ovf final
//            D     - result mod 2^WIDTH
//            bout  - borrow-out (sub) / carry-out (add)
//            ovf   - two's-complement signed overflow
// Revision : 1.0 - initial release
// ============================================================================
module lab_serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             bout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_d;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_mode;
  logic             r_cy;
  logic             r_bout;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;

  logic             w_ready;
  logic             w_busy;
  logic             w_done;
  logic             w_last;
  logic [DIGIT:0]   w_sum;
  logic [WIDTH-1:0] w_d_shift;
  logic             w_d_msb;
  logic             w_ovf;

  assign w_last = (r_cnt == C_CNT_LAST);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Digit slice. Operands shift right so the active digit is always at bit 0.
  // In subtract mode the (DIGIT+1)-bit difference wraps negative when a borrow
  // occurs, so its top bit is the borrow-out just as it is the carry in add.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (r_mode) begin
      w_sum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
            + {{DIGIT{1'b0}}, r_cy};
    end else begin
      w_sum = {1'b0, r_a[DIGIT-1:0]} - {1'b0, r_b[DIGIT-1:0]}
            - {{DIGIT{1'b0}}, r_cy};
    end
  end

  // Result digits enter at the top and move down; after N shifts digit 0
  // sits at bit 0.
  assign w_d_shift = (r_d >> DIGIT) | (WIDTH'(w_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
  assign w_d_msb   = w_d_shift[WIDTH-1];

  // Overflow uses the operand sign bits captured at start, since the operand
  // registers have been shifted out by the final digit.
  always_comb begin
    if (r_mode) begin
      w_ovf = (r_a_msb == r_b_msb) && (w_d_msb != r_a_msb);
    end else begin
      w_ovf = (r_a_msb != r_b_msb) && (w_d_msb != r_a_msb);
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_d     <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_mode  <= 1'b0;
      r_cy    <= 1'b0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_a_msb <= A[WIDTH-1];
            r_b_msb <= B[WIDTH-1];
            r_mode  <= mode;
            r_cy    <= bin;
            r_d     <= '0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_a  <= r_a >> DIGIT;
          r_b  <= r_b >> DIGIT;
          r_cy <= w_sum[DIGIT];
          r_d  <= w_d_shift;
          if (w_last) begin
            r_bout <= w_sum[DIGIT];
            r_ovf  <= w_ovf;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          // DONE: results hold
        end
      endcase
    end
  end

  assign ready = w_ready;
  assign busy  = w_busy;
  assign done  = w_done;
  assign D     = r_d;
  assign bout  = r_bout;
  assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_lab_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_lab_serial_addsub
// Purpose  : Self-checking bench for lab_serial_addsub. Six instances cover
//            WIDTH=16 with DIGIT 4/1/16 and WIDTH=4 with DIGIT 1/2/4.
//            Expected results are queued per instance when a request is
//            issued and compared when that instance pulses done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lab_serial_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  start_v;
  logic        mode;
  logic        bin;
  logic [15:0] a;
  logic [15:0] b;

  logic [5:0]  ready_v, busy_v, done_v, bout_v, ovf_v;
  logic [15:0] d0, d4, d5;
  logic [3:0]  d1, d2, d3;
  logic [15:0] dv [6];

  assign dv[0] = d0;
  assign dv[1] = {12'h000, d1};
  assign dv[2] = {12'h000, d2};
  assign dv[3] = {12'h000, d3};
  assign dv[4] = d4;
  assign dv[5] = d5;

  // instance order: u0(16,4) u1(4,1) u2(4,2) u3(4,4) u4(16,1) u5(16,16)
  int n_of [6] = '{4, 4, 2, 1, 16, 1};
  int w_of [6] = '{16, 4, 4, 4, 16, 16};

  typedef struct {
    logic [15:0] d;
    logic        bo;
    logic        ov;
    int          t0;
  } exp_t;

  exp_t sb [6][$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lab_serial_addsub #(.WIDTH(16), .DIGIT(4)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode), .A(a), .B(b), .bin(bin),
    .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]), .D(d0), .bout(bout_v[0]), .ovf(ovf_v[0]));
  lab_serial_addsub #(.WIDTH(4), .DIGIT(1)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode), .A(a[3:0]), .B(b[3:0]), .bin(bin),
    .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]), .D(d1), .bout(bout_v[1]), .ovf(ovf_v[1]));
  lab_serial_addsub #(.WIDTH(4), .DIGIT(2)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .mode(mode), .A(a[3:0]), .B(b[3:0]), .bin(bin),
    .ready(ready_v[2]), .busy(busy_v[2]), .done(done_v[2]), .D(d2), .bout(bout_v[2]), .ovf(ovf_v[2]));
  lab_serial_addsub #(.WIDTH(4), .DIGIT(4)) u3 (
    .clk(clk), .rst(rst), .start(start_v[3]), .mode(mode), .A(a[3:0]), .B(b[3:0]), .bin(bin),
    .ready(ready_v[3]), .busy(busy_v[3]), .done(done_v[3]), .D(d3), .bout(bout_v[3]), .ovf(ovf_v[3]));
  lab_serial_addsub #(.WIDTH(16), .DIGIT(1)) u4 (
    .clk(clk), .rst(rst), .start(start_v[4]), .mode(mode), .A(a), .B(b), .bin(bin),
    .ready(ready_v[4]), .busy(busy_v[4]), .done(done_v[4]), .D(d4), .bout(bout_v[4]), .ovf(ovf_v[4]));
  lab_serial_addsub #(.WIDTH(16), .DIGIT(16)) u5 (
    .clk(clk), .rst(rst), .start(start_v[5]), .mode(mode), .A(a), .B(b), .bin(bin),
    .ready(ready_v[5]), .busy(busy_v[5]), .done(done_v[5]), .D(d5), .bout(bout_v[5]), .ovf(ovf_v[5]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Reference arithmetic on w-bit operands using plain integer math.
  function automatic exp_t model(input int w, input logic md, input logic [15:0] aa,
                                 input logic [15:0] bb, input logic bi);
    exp_t        e;
    int unsigned mask, av, bv, full, am, bm, dm;
    mask = (32'd1 << w) - 32'd1;
    av   = 32'(aa) & mask;
    bv   = 32'(bb) & mask;
    if (md) begin
      full = av + bv + 32'(bi);
      e.bo = ((full >> w) & 32'd1) != 0;
    end else begin
      full = av - bv - 32'(bi);
      e.bo = av < (bv + 32'(bi));
    end
    e.d = 16'(full & mask);
    am  = (av >> (w - 1)) & 32'd1;
    bm  = (bv >> (w - 1)) & 32'd1;
    dm  = (32'(e.d) >> (w - 1)) & 32'd1;
    if (md) e.ov = (am == bm) && (dm != am);
    else    e.ov = (am != bm) && (dm != am);
    e.t0 = 0;
    return e;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < 6; i++) if (sb[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Scoreboard consumer: every done pulse pops one expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b0) begin
      for (int i = 0; i < 6; i++) begin
        if (done_v[i] === 1'b1) begin
          if (sb[i].size() == 0) begin
            check($sformatf("u%0d_spurious_done", i), 32'(done_v[i]), 32'd0);
          end else begin
            e = sb[i].pop_front();
            check($sformatf("u%0d_D", i), 32'(dv[i]), 32'(e.d));
            check($sformatf("u%0d_bout", i), 32'(bout_v[i]), 32'(e.bo));
            check($sformatf("u%0d_ovf", i), 32'(ovf_v[i]), 32'(e.ov));
            check($sformatf("u%0d_latency", i), 32'(cyc - e.t0), 32'(n_of[i]));
          end
        end
      end
    end
  end

  task automatic issue(input logic [5:0] mask, input logic md, input logic [15:0] aa,
                       input logic [15:0] bb, input logic bi);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (((ready_v & mask) != mask) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      check("ready_timeout", 32'(ready_v & mask), 32'(mask));
      return;
    end
    mode    = md;
    a       = aa;
    b       = bb;
    bin     = bi;
    start_v = mask;
    for (int i = 0; i < 6; i++) begin
      if (mask[i]) begin
        e    = model(w_of[i], md, aa, bb, bi);
        e.t0 = cyc + 1;
        sb[i].push_back(e);
      end
    end
    @(negedge clk);
    start_v = '0;
    for (int i = 0; i < 6; i++)
      if (mask[i]) check($sformatf("u%0d_accept_rdy_busy", i), 32'({ready_v[i], busy_v[i]}), 32'd1);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!(all_empty() && ready_v == 6'h3F) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("idle_timeout", 32'(ready_v), 32'h3F);
  endtask

  logic [3:0] la  [8] = '{4'h0, 4'h1, 4'h3, 4'h5, 4'h7, 4'h8, 4'hB, 4'hF};
  logic [3:0] lb  [8] = '{4'hC, 4'h2, 4'h6, 4'hB, 4'hA, 4'h1, 4'h6, 4'hF};
  logic       lbi [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin : main
    int   guard;
    int   acc [3];
    exp_t e;
    rst = 1'b1; start_v = '0; mode = 1'b0; bin = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++)
      check($sformatf("u%0d_reset_rdy_busy_done_bout_ovf", i),
            32'({ready_v[i], busy_v[i], done_v[i], bout_v[i], ovf_v[i]}), 32'h10);
    check("reset_D", 32'(d0), 32'd0);

    // Directed subtract/add cases on the 16/4 instance
    issue(6'h01, 1'b0, 16'h0000, 16'h000C, 1'b1); wait_idle();
    issue(6'h01, 1'b0, 16'h8000, 16'h0001, 1'b0); wait_idle();
    issue(6'h01, 1'b0, 16'h000F, 16'h000F, 1'b1); wait_idle();
    issue(6'h01, 1'b1, 16'hFFFF, 16'h0001, 1'b0); wait_idle();
    issue(6'h01, 1'b1, 16'h7FFF, 16'h0001, 1'b0); wait_idle();

    // Requests while busy are ignored
    issue(6'h01, 1'b0, 16'h0007, 16'h000A, 1'b1);
    start_v[0] = 1'b1; a = 16'h1111; b = 16'h0001;
    repeat (2) @(negedge clk);
    start_v[0] = 1'b0;
    guard = 0;
    while (done_v[0] !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    check("busy_req_done_seen", 32'(done_v[0]), 32'd1);
    @(negedge clk);
    check("after_done_rdy_busy_done", 32'({ready_v[0], busy_v[0], done_v[0]}), 32'h4);
    wait_idle();

    // Reset mid-operation, with start asserted alongside reset
    issue(6'h01, 1'b0, 16'h1234, 16'h0042, 1'b0);
    @(negedge clk);
    rst = 1'b1; start_v[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0; start_v[0] = 1'b0;
    sb[0].delete();
    check("midrst_rdy_busy_done_bout_ovf",
          32'({ready_v[0], busy_v[0], done_v[0], bout_v[0], ovf_v[0]}), 32'h10);
    check("midrst_D", 32'(d0), 32'd0);
    issue(6'h01, 1'b0, 16'h000B, 16'h0006, 1'b0); wait_idle();

    // Start held high: back-to-back launches every N+2 cycles
    mode = 1'b1; a = 16'h1234; b = 16'h0FFF; bin = 1'b0;
    start_v[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      guard = 0;
      while (ready_v[0] !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
      e = model(16, 1'b1, 16'h1234, 16'h0FFF, 1'b0);
      e.t0 = cyc + 1;
      acc[k] = cyc + 1;
      sb[0].push_back(e);
      @(negedge clk);
    end
    start_v[0] = 1'b0;
    check("period_0_1", 32'(acc[1] - acc[0]), 32'd6);
    check("period_1_2", 32'(acc[2] - acc[1]), 32'd6);
    wait_idle();

    // Legacy 4-bit vectors on every configuration
    for (int i = 0; i < 8; i++) begin
      issue(6'h3F, 1'b0, {12'h000, la[i]}, {12'h000, lb[i]}, lbi[i]);
      wait_idle();
    end

    // Random add/sub on every configuration
    for (int i = 0; i < 1000; i++) begin
      issue(6'h3F, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
            1'($urandom_range(0, 1)));
    end
    wait_idle();
    for (int i = 0; i < 6; i++)
      check($sformatf("u%0d_sb_drained", i), 32'(sb[i].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
